// File: rtl/inst_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_queue_pkg : widths, PC step and entry type shared by fetch/ID/EX      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package inst_queue_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } iq_entry_t;

  function automatic logic [1:0] iq_min2(input logic [1:0] a, input logic [1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_queue_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_queue_ram : DEPTH x {pc,instr} array, 2 write / 2 read ports, each    |
// | pair at consecutive addresses. Rev 1.0                                     |
// +----------------------------------------------------------------------------+
module inst_queue_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  iq_entry_t         wdata0_i,
  input  iq_entry_t         wdata1_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output iq_entry_t         rdata0_o,
  output iq_entry_t         rdata1_o
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  iq_entry_t         mem_q [DEPTH];
  logic [ADDR_W-1:0] waddr1;
  logic [ADDR_W-1:0] raddr1;

  assign waddr1 = waddr_i + ADDR_ONE;
  assign raddr1 = raddr_i + ADDR_ONE;

  // Storage is deliberately left unreset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we0_i) mem_q[waddr_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1]  <= wdata1_i;
  end

  assign rdata0_o = mem_q[raddr_i];
  assign rdata1_o = mem_q[raddr1];

endmodule
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_queue : dual-issue instruction buffer, fetch -> ID. Optional empty-   |
// | queue bypass under INST_QUEUE_BYPASS_EN. Rev 1.0                           |
// +----------------------------------------------------------------------------+
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid_first,
  input  logic               in_valid_second,
  input  logic [PC_W-1:0]    in_pc_first,
  input  logic [INSTR_W-1:0] in_instr_first,
  input  logic [INSTR_W-1:0] in_instr_second,
  output logic               in_ready,
  input  logic [1:0]         issue_count,
  output logic               out_first_valid,
  output logic [PC_W-1:0]    out_first_pc,
  output logic [INSTR_W-1:0] out_first_instr,
  output logic               out_second_valid,
  output logic [PC_W-1:0]    out_second_pc,
  output logic [INSTR_W-1:0] out_second_instr,
  output logic [ADDR_W:0]    occupancy
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] TWO_C   = (ADDR_W+1)'(2);

  logic [ADDR_W:0] wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W:0] occ, avail;
  logic [1:0]      n_in, n_out, iss, avail_sat;
  iq_entry_t       in0, in1, rd0, rd1, first_e, second_e;

  assign occ      = wr_q - rd_q;
  assign in_ready = (DEPTH_C - occ) >= TWO_C;

  always_comb begin
    n_in = 2'd0;
    if (in_valid_first && in_ready) n_in = in_valid_second ? 2'd2 : 2'd1;
  end

  assign in0 = '{pc: in_pc_first,          instr: in_instr_first};
  assign in1 = '{pc: in_pc_first + PC_INC, instr: in_instr_second};

`ifdef INST_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass   = (occ == '0) && (n_in != 2'd0);
  assign avail    = bypass ? (ADDR_W+1)'(n_in) : occ;
  assign first_e  = bypass ? in0 : rd0;
  assign second_e = bypass ? in1 : rd1;
`else
  assign avail    = occ;
  assign first_e  = rd0;
  assign second_e = rd1;
`endif

  assign avail_sat = (avail >= TWO_C) ? 2'd2 : avail[1:0];
  assign iss       = (issue_count == 2'd3) ? 2'd2 : issue_count;
  assign n_out     = iq_min2(iss, avail_sat);

  // Flush wins over both the same-cycle enqueue and the retire count.
  always_comb begin
    wr_d = wr_q + (ADDR_W+1)'(n_in);
    rd_d = rd_q + (ADDR_W+1)'(n_out);
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  inst_queue_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .we0_i    ((n_in != 2'd0) && !flush),
    .we1_i    ((n_in == 2'd2) && !flush),
    .waddr_i  (wr_q[ADDR_W-1:0]),
    .wdata0_i (in0),
    .wdata1_i (in1),
    .raddr_i  (rd_q[ADDR_W-1:0]),
    .rdata0_o (rd0),
    .rdata1_o (rd1)
  );

  assign out_first_valid  = avail >= (ADDR_W+1)'(1);
  assign out_second_valid = avail >= TWO_C;
  assign out_first_pc     = out_first_valid  ? first_e.pc     : '0;
  assign out_first_instr  = out_first_valid  ? first_e.instr  : '0;
  assign out_second_pc    = out_second_valid ? second_e.pc    : '0;
  assign out_second_instr = out_second_valid ? second_e.instr : '0;
  assign occupancy        = occ;

endmodule
`default_nettype wire
